scsi_fifo_ctl: RTL and testbench

Eight-longword data FIFO with pointer, byte-offset and fill-level control, sitting directly beside the SCSI state machine. It receives that machine's INCFIFO/DECFIFO/INCBO/INCNI/INCNO strobes. It returns FIFOFULL, FIFOEMPTY and BOEQ3. It stores the data moved between the WD33C93 byte port (S2F/F2S) and the 32-bit host bus.

---
 rtl/sdmac_pkg.sv | 45 ++++
 rtl/scsi_fifo_ram.sv | 33 +++
 rtl/scsi_fifo_ctl.sv | 168 ++++++++++++++++
 tb/tb_scsi_fifo_ctl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdmac_pkg.sv
// sdmac_pkg -- constants, the longword type and the byte-lane helpers
// used by the SCSI DMA FIFO.
//
// Byte lanes are big-endian with respect to the byte offset BO:
//   BO=0 -> bits 31:24, BO=1 -> 23:16, BO=2 -> 15:8, BO=3 -> 7:0.
// Physical lane l always covers bits 8*l+7 : 8*l.
package sdmac_pkg;

   localparam int FIFO_DEPTH_LOG2 = 3;
   localparam int FIFO_DEPTH      = 1 << FIFO_DEPTH_LOG2;
   localparam int BO_W            = 2;

   typedef logic [31:0] longword_t;

   // Least significant bit of the byte lane addressed by a byte offset.
   function automatic logic [4:0] lane_lsb(input logic [BO_W-1:0] bo);
      logic [4:0] lsb;
      case (bo)
         2'd0:    lsb = 5'd24;
         2'd1:    lsb = 5'd16;
         2'd2:    lsb = 5'd8;
         default: lsb = 5'd0;
      endcase
      return lsb;
   endfunction

   // One-hot physical lane enable for a byte offset (bit l enables lane l).
   function automatic logic [3:0] lane_mask(input logic [BO_W-1:0] bo);
      logic [3:0] mask;
      case (bo)
         2'd0:    mask = 4'b1000;
         2'd1:    mask = 4'b0100;
         2'd2:    mask = 4'b0010;
         default: mask = 4'b0001;
      endcase
      return mask;
   endfunction

   // Byte of a longword selected by a byte offset.
   function automatic logic [7:0] lane_byte(input longword_t w,
                                            input logic [BO_W-1:0] bo);
      return w[lane_lsb(bo) +: 8];
   endfunction

endpackage

// File: rtl/scsi_fifo_ram.sv
// scsi_fifo_ram -- longword register array for the SCSI DMA FIFO.
// One write port with per-lane byte enables and one asynchronous read port.
// Contents are never cleared; reset and flush only affect the control side.
module scsi_fifo_ram
   import sdmac_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic [3:0]            lane_we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  longword_t             wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output longword_t             rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   longword_t mem [DEPTH];

   // Byte-lane write into the addressed entry; untouched lanes keep their data.
   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (lane_we[l]) begin
            mem[waddr][8*l +: 8] <= wdata[8*l +: 8];
         end
      end
   end

   // Reads see registered contents only, so a same-cycle write is not bypassed.
   assign rdata = mem[raddr];

endmodule

// File: rtl/scsi_fifo_ctl.sv
// scsi_fifo_ctl -- eight-longword data FIFO beside the SCSI state machine.
// Holds the write/read pointers, the shared byte offset and the fill level,
// decodes FIFOFULL/FIFOEMPTY/BOEQ3 from registered state and steers the
// host longword path and the WD33C93 byte path into the storage array.
//
// Optional feature: define SCSI_FIFO_ERRFLAGS_EN to add the sticky OVF/UNF
// flags and their ERRCLR input.
module scsi_fifo_ctl
   import sdmac_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
   input  logic                  CPUCLK,
   input  logic                  RESET,
   input  logic                  FLUSH,
   input  logic                  INCFIFO,
   input  logic                  DECFIFO,
   input  logic                  INCNI,
   input  logic                  INCNO,
   input  logic                  INCBO,
   input  logic                  LW_WE,
   input  logic                  BYTE_WE,
   input  logic [31:0]           DIN_LW,
   input  logic [7:0]            DIN_BYTE,
   output logic                  FIFOFULL,
   output logic                  FIFOEMPTY,
   output logic                  BOEQ3,
   output logic [BO_W-1:0]       BO,
   output logic [DEPTH_LOG2-1:0] WPTR,
   output logic [DEPTH_LOG2-1:0] RPTR,
   output logic [DEPTH_LOG2:0]   LEVEL,
   output logic [31:0]           DOUT_LW,
   output logic [7:0]            DOUT_BYTE
`ifdef SCSI_FIFO_ERRFLAGS_EN
   ,
   input  logic                  ERRCLR,
   output logic                  OVF,
   output logic                  UNF
`endif
);

   localparam logic [DEPTH_LOG2:0] LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] LEVEL_MIN = '0;

   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [BO_W-1:0]       bo;
   logic [DEPTH_LOG2:0]   level;

   logic                  clear;
   logic                  level_up;
   logic                  level_down;
   logic                  at_full;
   logic                  at_empty;
   logic [3:0]            lane_we;
   longword_t             wdata;
   longword_t             rdata;

   // Reset and flush both clear the control state and mask every strobe.
   assign clear = RESET | FLUSH;

   assign at_full  = (level == LEVEL_MAX);
   assign at_empty = (level == LEVEL_MIN);

   // Level moves only on a lone INCFIFO or DECFIFO and saturates at both ends;
   // a simultaneous pair cancels out even at the limits.
   assign level_up   = INCFIFO & ~DECFIFO & ~at_full;
   assign level_down = DECFIFO & ~INCFIFO & ~at_empty;

   // Fill level counter.
   always_ff @(posedge CPUCLK) begin
      if (clear) begin
         level <= '0;
      end else if (level_up) begin
         level <= level + 1'b1;
      end else if (level_down) begin
         level <= level - 1'b1;
      end
   end

   // Write pointer; wraps naturally at the array depth and ignores the level.
   always_ff @(posedge CPUCLK) begin
      if (clear) begin
         wptr <= '0;
      end else if (INCNI) begin
         wptr <= wptr + 1'b1;
      end
   end

   // Read pointer; same free-running behaviour as the write pointer.
   always_ff @(posedge CPUCLK) begin
      if (clear) begin
         rptr <= '0;
      end else if (INCNO) begin
         rptr <= rptr + 1'b1;
      end
   end

   // Byte offset shared by the byte write path and the byte read path.
   always_ff @(posedge CPUCLK) begin
      if (clear) begin
         bo <= '0;
      end else if (INCBO) begin
         bo <= bo + 1'b1;
      end
   end

   // Lane enables and write data: a longword write takes all lanes and wins
   // over a byte write; a byte write is replicated and lands in lane BO.
   always_comb begin
      lane_we = 4'b0000;
      wdata   = DIN_LW;
      if (!clear) begin
         if (LW_WE) begin
            lane_we = 4'b1111;
            wdata   = DIN_LW;
         end else if (BYTE_WE) begin
            lane_we = lane_mask(bo);
            wdata   = {4{DIN_BYTE}};
         end
      end
   end

   scsi_fifo_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk     (CPUCLK),
      .lane_we (lane_we),
      .waddr   (wptr),
      .wdata   (wdata),
      .raddr   (rptr),
      .rdata   (rdata)
   );

`ifdef SCSI_FIFO_ERRFLAGS_EN
   logic ovf;
   logic unf;

   // Sticky overflow/underflow capture of the strobes the level counter drops.
   always_ff @(posedge CPUCLK) begin
      if (clear || ERRCLR) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (INCFIFO && !DECFIFO && at_full) begin
            ovf <= 1'b1;
         end
         if (DECFIFO && !INCFIFO && at_empty) begin
            unf <= 1'b1;
         end
      end
   end

   assign OVF = ovf;
   assign UNF = unf;
`endif

   assign FIFOFULL  = at_full;
   assign FIFOEMPTY = at_empty;
   assign BOEQ3     = (bo == 2'd3);
   assign BO        = bo;
   assign WPTR      = wptr;
   assign RPTR      = rptr;
   assign LEVEL     = level;
   assign DOUT_LW   = rdata;
   assign DOUT_BYTE = lane_byte(rdata, bo);

endmodule

// File: tb/tb_scsi_fifo_ctl.sv
// tb_scsi_fifo_ctl -- self-checking bench for scsi_fifo_ctl.
// A behavioural FIFO model is updated after every rising edge and checked
// against the DUT on every falling edge; directed literal checks pin the model.
// Define SCSI_FIFO_ERRFLAGS_EN to also exercise OVF/UNF/ERRCLR.
module tb_scsi_fifo_ctl;

   localparam logic [9:0] S_RST    = 10'h001;
   localparam logic [9:0] S_FLUSH  = 10'h002;
   localparam logic [9:0] S_INCF   = 10'h004;
   localparam logic [9:0] S_DECF   = 10'h008;
   localparam logic [9:0] S_INCNI  = 10'h010;
   localparam logic [9:0] S_INCNO  = 10'h020;
   localparam logic [9:0] S_INCBO  = 10'h040;
   localparam logic [9:0] S_LW     = 10'h080;
   localparam logic [9:0] S_BW     = 10'h100;
   localparam logic [9:0] S_ERRCLR = 10'h200;

   logic        CPUCLK = 1'b0;
   logic        RESET = 1'b1, FLUSH = 1'b0, INCFIFO = 1'b0, DECFIFO = 1'b0;
   logic        INCNI = 1'b0, INCNO = 1'b0, INCBO = 1'b0;
   logic        LW_WE = 1'b0, BYTE_WE = 1'b0, ERRCLR = 1'b0;
   logic [31:0] DIN_LW = '0;
   logic [7:0]  DIN_BYTE = '0;
   logic        FIFOFULL, FIFOEMPTY, BOEQ3;
   logic [1:0]  BO;
   logic [2:0]  WPTR, RPTR;
   logic [3:0]  LEVEL;
   logic [31:0] DOUT_LW;
   logic [7:0]  DOUT_BYTE;
   logic        OVF, UNF;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   // Behavioural model state.
   int          m_level = 0, m_wptr = 0, m_rptr = 0, m_bo = 0;
   logic [31:0] m_mem [8];
   logic [3:0]  m_lanes [8];
   bit          m_ovf = 1'b0, m_unf = 1'b0;

   scsi_fifo_ctl dut (
      .CPUCLK    (CPUCLK),
      .RESET     (RESET),
      .FLUSH     (FLUSH),
      .INCFIFO   (INCFIFO),
      .DECFIFO   (DECFIFO),
      .INCNI     (INCNI),
      .INCNO     (INCNO),
      .INCBO     (INCBO),
      .LW_WE     (LW_WE),
      .BYTE_WE   (BYTE_WE),
      .DIN_LW    (DIN_LW),
      .DIN_BYTE  (DIN_BYTE),
      .FIFOFULL  (FIFOFULL),
      .FIFOEMPTY (FIFOEMPTY),
      .BOEQ3     (BOEQ3),
      .BO        (BO),
      .WPTR      (WPTR),
      .RPTR      (RPTR),
      .LEVEL     (LEVEL),
      .DOUT_LW   (DOUT_LW),
      .DOUT_BYTE (DOUT_BYTE)
`ifdef SCSI_FIFO_ERRFLAGS_EN
      ,
      .ERRCLR    (ERRCLR),
      .OVF       (OVF),
      .UNF       (UNF)
`endif
   );

`ifndef SCSI_FIFO_ERRFLAGS_EN
   assign OVF = 1'b0;
   assign UNF = 1'b0;
`endif

   always #5 CPUCLK = ~CPUCLK;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Drive one cycle of strobes, then advance the model from those strobes.
   task automatic applyStimulus(input logic [9:0] s, input logic [31:0] dlw,
                                input logic [7:0] db);
      int          k;
      logic [31:0] w;
      RESET = s[0]; FLUSH = s[1]; INCFIFO = s[2]; DECFIFO = s[3];
      INCNI = s[4]; INCNO = s[5]; INCBO = s[6]; LW_WE = s[7];
      BYTE_WE = s[8]; ERRCLR = s[9]; DIN_LW = dlw; DIN_BYTE = db;
      @(posedge CPUCLK);
      if (s[0] || s[1]) begin
         m_level = 0; m_wptr = 0; m_rptr = 0; m_bo = 0;
         m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         if (s[7]) begin
            m_mem[m_wptr]   = dlw;
            m_lanes[m_wptr] = 4'hF;
         end else if (s[8]) begin
            k = 3 - m_bo;
            w = m_mem[m_wptr];
            w[8*k +: 8] = db;
            m_mem[m_wptr] = w;
            m_lanes[m_wptr][k] = 1'b1;
         end
`ifdef SCSI_FIFO_ERRFLAGS_EN
         if (s[9]) begin
            m_ovf = 1'b0; m_unf = 1'b0;
         end else begin
            if (s[2] && !s[3] && m_level == 8) m_ovf = 1'b1;
            if (s[3] && !s[2] && m_level == 0) m_unf = 1'b1;
         end
`endif
         if (s[2] && !s[3] && m_level < 8) m_level = m_level + 1;
         else if (s[3] && !s[2] && m_level > 0) m_level = m_level - 1;
         if (s[4]) m_wptr = (m_wptr + 1) % 8;
         if (s[5]) m_rptr = (m_rptr + 1) % 8;
         if (s[6]) m_bo = (m_bo + 1) % 4;
      end
      @(negedge CPUCLK);
      #1;
   endtask

   // Every-cycle comparison of the DUT against the model.
   always @(negedge CPUCLK) begin
      logic [31:0] w;
      if (check_en) begin
         checkOutput("LEVEL", 32'(LEVEL), 32'(m_level));
         checkOutput("WPTR", 32'(WPTR), 32'(m_wptr));
         checkOutput("RPTR", 32'(RPTR), 32'(m_rptr));
         checkOutput("BO", 32'(BO), 32'(m_bo));
         checkOutput("FIFOFULL", 32'(FIFOFULL), 32'(m_level == 8));
         checkOutput("FIFOEMPTY", 32'(FIFOEMPTY), 32'(m_level == 0));
         checkOutput("BOEQ3", 32'(BOEQ3), 32'(m_bo == 3));
`ifdef SCSI_FIFO_ERRFLAGS_EN
         checkOutput("OVF", 32'(OVF), 32'(m_ovf));
         checkOutput("UNF", 32'(UNF), 32'(m_unf));
`endif
         w = m_mem[m_rptr];
         if (m_lanes[m_rptr] == 4'hF) begin
            checkOutput("DOUT_LW", DOUT_LW, w);
         end
         if (m_lanes[m_rptr][3 - m_bo]) begin
            checkOutput("DOUT_BYTE", 32'(DOUT_BYTE), (w >> (8 * (3 - m_bo))) & 32'hFF);
         end
      end
   end

   initial begin
      logic [7:0] pack_bytes [4];
      logic [7:0] drain_bytes [4];
      pack_bytes  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      drain_bytes = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      for (int i = 0; i < 8; i++) m_lanes[i] = 4'h0;

      // Power-on reset.
      applyStimulus(S_RST, 32'h0, 8'h0);
      applyStimulus(S_RST, 32'h0, 8'h0);
      check_en = 1'b1;
      checkOutput("reset_level", 32'(LEVEL), 32'd0);
      checkOutput("reset_empty", 32'(FIFOEMPTY), 32'd1);
      checkOutput("reset_boeq3", 32'(BOEQ3), 32'd0);

      // Fill all eight entries with write, pointer advance and level increment.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(S_LW | S_INCNI | S_INCF, 32'(i) * 32'h11111111, 8'h0);
      end
      checkOutput("fill_full", 32'(FIFOFULL), 32'd1);
      checkOutput("fill_wptr_wrap", 32'(WPTR), 32'd0);
      checkOutput("fill_entry0", DOUT_LW, 32'h11111111);
      applyStimulus(S_INCF, 32'h0, 8'h0);
      checkOutput("ninth_incfifo_level", 32'(LEVEL), 32'd8);
`ifdef SCSI_FIFO_ERRFLAGS_EN
      checkOutput("ninth_incfifo_ovf", 32'(OVF), 32'd1);
      applyStimulus(S_ERRCLR, 32'h0, 8'h0);
`endif
      applyStimulus(S_INCF | S_DECF, 32'h0, 8'h0);
      checkOutput("simul_at_full_level", 32'(LEVEL), 32'd8);
      checkOutput("simul_at_full_ovf", 32'(OVF), 32'd0);

      // Partial drain by longwords.
      for (int i = 0; i < 3; i++) applyStimulus(S_INCNO | S_DECF, 32'h0, 8'h0);
      checkOutput("drain_level", 32'(LEVEL), 32'd5);
      checkOutput("drain_entry3", DOUT_LW, 32'h44444444);

      // Reset mid-transfer at level 5; storage survives.
      applyStimulus(S_RST | S_INCF, 32'h0, 8'h0);
      applyStimulus(S_RST, 32'h0, 8'h0);
      checkOutput("rst_level", 32'(LEVEL), 32'd0);
      checkOutput("rst_rptr", 32'(RPTR), 32'd0);
      checkOutput("rst_full", 32'(FIFOFULL), 32'd0);
      checkOutput("rst_retained", DOUT_LW, 32'h11111111);

      // Byte packing through the shared byte offset.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(S_BW | S_INCBO, 32'h0, pack_bytes[k]);
         if (k == 2) checkOutput("pack_boeq3", 32'(BOEQ3), 32'd1);
      end
      checkOutput("pack_bo_wrap", 32'(BO), 32'd0);
      checkOutput("pack_word", DOUT_LW, 32'hDEADBEEF);

      // Longword write wins over a simultaneous byte write.
      applyStimulus(S_LW | S_BW, 32'hCAFEF00D, 8'h55);
      checkOutput("lw_wins", DOUT_LW, 32'hCAFEF00D);

      // Drain the entry byte by byte.
      checkOutput("drain_byte0", 32'(DOUT_BYTE), 32'(drain_bytes[0]));
      for (int k = 1; k < 4; k++) begin
         applyStimulus(S_INCBO, 32'h0, 8'h0);
         checkOutput("drain_byte", 32'(DOUT_BYTE), 32'(drain_bytes[k]));
      end
      applyStimulus(S_INCBO, 32'h0, 8'h0);

      // Simultaneous increment/decrement and lone decrement at empty.
      applyStimulus(S_INCF | S_DECF, 32'h0, 8'h0);
      checkOutput("simul_at_empty_level", 32'(LEVEL), 32'd0);
      checkOutput("simul_at_empty_unf", 32'(UNF), 32'd0);
      applyStimulus(S_DECF, 32'h0, 8'h0);
      checkOutput("dec_at_empty_level", 32'(LEVEL), 32'd0);
`ifdef SCSI_FIFO_ERRFLAGS_EN
      checkOutput("dec_at_empty_unf", 32'(UNF), 32'd1);
      applyStimulus(S_ERRCLR, 32'h0, 8'h0);
      checkOutput("errclr_unf", 32'(UNF), 32'd0);
`endif

      // Flush mid-transfer with strobes in the same cycle.
      for (int i = 0; i < 3; i++) applyStimulus(S_INCF, 32'h0, 8'h0);
      applyStimulus(S_INCBO | S_INCNI | S_INCNO, 32'h0, 8'h0);
      applyStimulus(S_INCBO, 32'h0, 8'h0);
      checkOutput("pre_flush_level", 32'(LEVEL), 32'd3);
      checkOutput("pre_flush_bo", 32'(BO), 32'd2);
      applyStimulus(S_FLUSH | S_INCF | S_INCBO | S_INCNI, 32'h0, 8'h0);
      checkOutput("flush_level", 32'(LEVEL), 32'd0);
      checkOutput("flush_bo", 32'(BO), 32'd0);
      checkOutput("flush_wptr", 32'(WPTR), 32'd0);
      checkOutput("flush_retained", DOUT_LW, 32'hCAFEF00D);
      applyStimulus(10'h0, 32'h0, 8'h0);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
